wght_spad_ctrl: RTL and testbench

- Per-PE weight scratchpad and controller, sitting directly downstream of the weight router.
- Captures the weight burst the router presents on w_data_spad/load_en_spad into a local array.
- Marks the filter as loaded, then streams one kernel row at a time to the PE's MAC datapath on request.
- Owns the write pointer, load-completion detection, overflow flagging, and a read sequencer with a valid/last stream.

---
 rtl/wght_spad_ctrl_pkg.sv | 20 ++
 rtl/wght_spad_ctrl_mem.sv | 27 ++
 rtl/wght_spad_ctrl.sv | 151 +++++++++++++++
 tb/tb_wght_spad_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wght_spad_ctrl_pkg.sv
// rtl/wght_spad_ctrl_pkg.sv - shared constants, FSM encoding and helpers for the weight scratchpad
package wght_spad_ctrl_pkg;

    localparam int DEFAULT_DATA_BITWIDTH      = 16;
    localparam int DEFAULT_ADDR_BITWIDTH_SPAD = 9;

    typedef enum logic [2:0] {
        S_EMPTY,
        S_LOAD,
        S_READY,
        S_RD_ADDR,
        S_RD_STREAM
    } spad_state_t;

    // Number of words in a full KERNEL_SIZE x KERNEL_SIZE filter
    function automatic int kernel_words(input int kernel_size);
        return kernel_size * kernel_size;
    endfunction

endpackage

// File: rtl/wght_spad_ctrl_mem.sv
// rtl/wght_spad_ctrl_mem.sv - 1-write / 1-registered-read weight array, contents not reset
module spad_mem_1r1w #(
    parameter int DATA_BITWIDTH      = 16,
    parameter int ADDR_BITWIDTH_SPAD = 9
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [ADDR_BITWIDTH_SPAD-1:0] wr_addr,
    input  logic [DATA_BITWIDTH-1:0]      wr_data,
    input  logic                          rd_en,
    input  logic [ADDR_BITWIDTH_SPAD-1:0] rd_addr,
    output logic [DATA_BITWIDTH-1:0]      rd_data
);

    logic [DATA_BITWIDTH-1:0] mem [2**ADDR_BITWIDTH_SPAD];

    // Synchronous write and registered read; no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/wght_spad_ctrl.sv
// rtl/wght_spad_ctrl.sv - per-PE weight scratchpad: burst capture, load tracking, row streaming
module wght_spad_ctrl
    import wght_spad_ctrl_pkg::*;
#(
    parameter int DATA_BITWIDTH      = DEFAULT_DATA_BITWIDTH,
    parameter int ADDR_BITWIDTH_SPAD = DEFAULT_ADDR_BITWIDTH_SPAD,
    parameter int KERNEL_SIZE        = 3,
    parameter int ROW_BITWIDTH       = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITWIDTH-1:0]      w_data_spad,
    input  logic                          load_en_spad,
    input  logic                          clear,
    input  logic                          rd_start,
    input  logic [ROW_BITWIDTH-1:0]       rd_row,
    output logic                          rd_ready,
    output logic [DATA_BITWIDTH-1:0]      rd_data,
    output logic                          rd_valid,
    output logic                          rd_last,
    output logic                          wght_loaded,
    output logic [ADDR_BITWIDTH_SPAD-1:0] wght_count,
    output logic                          load_overflow
);

    localparam int                          K_WORDS_INT = kernel_words(KERNEL_SIZE);
    localparam logic [ADDR_BITWIDTH_SPAD-1:0] K_WORDS   = ADDR_BITWIDTH_SPAD'(K_WORDS_INT);
    localparam logic [ADDR_BITWIDTH_SPAD-1:0] K_SIZE    = ADDR_BITWIDTH_SPAD'(KERNEL_SIZE);
    localparam logic [ADDR_BITWIDTH_SPAD-1:0] K_LAST    = ADDR_BITWIDTH_SPAD'(KERNEL_SIZE - 1);

    // The pointer must be able to hold the full-filter count without wrapping
    if (K_WORDS_INT > 2**ADDR_BITWIDTH_SPAD - 1) begin : g_bad_geometry
        $error("wght_spad_ctrl: KERNEL_SIZE**2 does not fit the spad address width");
    end

    spad_state_t                   state, state_next;
    logic [ADDR_BITWIDTH_SPAD-1:0] wr_ptr;
    logic [ADDR_BITWIDTH_SPAD-1:0] wr_ptr_inc;
    logic [ADDR_BITWIDTH_SPAD-1:0] base;
    logic [ADDR_BITWIDTH_SPAD-1:0] rd_idx;
    logic [DATA_BITWIDTH-1:0]      mem_q;
    logic                          overflow_q;
    logic                          valid_q;
    logic                          last_q;
    logic                          wr_room;
    logic                          accept_wr;
    logic                          ovf_hit;
    logic                          row_ok;
    logic                          start_ok;
    logic                          issue;

    assign wr_ptr_inc = wr_ptr + ADDR_BITWIDTH_SPAD'(1);
    assign wr_room    = (state == S_EMPTY) || ((state == S_LOAD) && (wr_ptr < K_WORDS));
    assign accept_wr  = load_en_spad && !clear && wr_room;
    assign ovf_hit    = load_en_spad && !clear && !wr_room;
    assign row_ok     = 32'(rd_row) < KERNEL_SIZE;
    assign start_ok   = (state == S_READY) && rd_start && row_ok && !clear;
    // One array read per cycle from S_RD_ADDR until KERNEL_SIZE reads are in flight
    assign issue      = (state == S_RD_ADDR) || ((state == S_RD_STREAM) && (rd_idx < K_SIZE));

    spad_mem_1r1w #(
        .DATA_BITWIDTH      (DATA_BITWIDTH),
        .ADDR_BITWIDTH_SPAD (ADDR_BITWIDTH_SPAD)
    ) u_mem (
        .clk     (clk),
        .wr_en   (accept_wr),
        .wr_addr (wr_ptr),
        .wr_data (w_data_spad),
        .rd_en   (issue),
        .rd_addr (base + rd_idx),
        .rd_data (mem_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear overrides every other event
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept_wr) begin
                        state_next = (wr_ptr_inc >= K_WORDS) ? S_READY : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!accept_wr || (wr_ptr_inc >= K_WORDS)) begin
                        state_next = S_READY;
                    end
                end
                S_READY: begin
                    if (start_ok) begin
                        state_next = S_RD_ADDR;
                    end
                end
                S_RD_ADDR:   state_next = S_RD_STREAM;
                S_RD_STREAM: begin
                    if (rd_idx == K_SIZE) begin
                        state_next = S_READY;
                    end
                end
                default:     state_next = S_EMPTY;
            endcase
        end
    end

    // Write pointer, sticky overflow, read sequencer and stream flags
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr     <= '0;
            overflow_q <= 1'b0;
            base       <= '0;
            rd_idx     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            if (accept_wr) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (ovf_hit) begin
                overflow_q <= 1'b1;
            end
            if (start_ok) begin
                base   <= ADDR_BITWIDTH_SPAD'(rd_row) * K_SIZE;
                rd_idx <= '0;
            end else if (issue) begin
                rd_idx <= rd_idx + ADDR_BITWIDTH_SPAD'(1);
            end
            valid_q <= issue;
            last_q  <= issue && (rd_idx == K_LAST);
        end
    end

    assign rd_ready      = (state == S_READY);
    assign wght_loaded   = (state == S_READY) || (state == S_RD_ADDR) || (state == S_RD_STREAM);
    assign wght_count    = wr_ptr;
    assign load_overflow = overflow_q;
    assign rd_valid      = valid_q;
    assign rd_last       = last_q;
    assign rd_data       = valid_q ? mem_q : '0;

endmodule

// File: tb/tb_wght_spad_ctrl.sv
// tb/tb_wght_spad_ctrl.sv - directed table-driven bench for wght_spad_ctrl
module tb_wght_spad_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] w_data_spad;
    logic        load_en_spad;
    logic        clear;
    logic        rd_start;
    logic [3:0]  rd_row;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        wght_loaded;
    logic [8:0]  wght_count;
    logic        load_overflow;

    int tests = 0;
    int fails = 0;

    wght_spad_ctrl #(
        .DATA_BITWIDTH      (16),
        .ADDR_BITWIDTH_SPAD (9),
        .KERNEL_SIZE        (3),
        .ROW_BITWIDTH       (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .w_data_spad   (w_data_spad),
        .load_en_spad  (load_en_spad),
        .clear         (clear),
        .rd_start      (rd_start),
        .rd_row        (rd_row),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_last       (rd_last),
        .wght_loaded   (wght_loaded),
        .wght_count    (wght_count),
        .load_overflow (load_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        le;
        logic [15:0] d;
        logic        clr;
        logic        st;
        logic [3:0]  row;
        logic        ev;
        logic        el;
        logic [15:0] ed;
        logic [8:0]  ec;
        logic        eld;
        logic        erdy;
        logic        eovf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic le, input logic [15:0] d, input logic clr, input logic st,
                       input logic [3:0] row, input logic ev, input logic el, input logic [15:0] ed,
                       input logic [8:0] ec, input logic eld, input logic erdy, input logic eovf);
        vec_t v;
        v.le = le; v.d = d; v.clr = clr; v.st = st; v.row = row;
        v.ev = ev; v.el = el; v.ed = ed; v.ec = ec; v.eld = eld; v.erdy = erdy; v.eovf = eovf;
        vq.push_back(v);
    endtask

    task automatic drive(input logic le, input logic [15:0] d, input logic clr,
                         input logic st, input logic [3:0] row);
        load_en_spad = le;
        w_data_spad  = d;
        clear        = clr;
        rd_start     = st;
        rd_row       = row;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] outs();
        return {rd_valid, rd_last, rd_data, wght_count, wght_loaded, rd_ready, load_overflow};
    endfunction

    task automatic load_words(input int n, input logic [15:0] d0);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, d0 + 16'(i), 1'b0, 1'b0, 4'd0);
            step();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic read_row(input string name, input logic [3:0] row,
                            input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        drive(1'b0, 16'h0, 1'b0, 1'b1, row);
        step();
        chk({name, "_addr_ready"}, 32'(rd_ready), 32'd0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'd0);
        step();
        chk({name, "_w0"}, {14'd0, rd_valid, rd_last, rd_data}, {14'd0, 1'b1, 1'b0, e0});
        step();
        chk({name, "_w1"}, {14'd0, rd_valid, rd_last, rd_data}, {14'd0, 1'b1, 1'b0, e1});
        step();
        chk({name, "_w2"}, {14'd0, rd_valid, rd_last, rd_data}, {14'd0, 1'b1, 1'b1, e2});
        step();
        chk({name, "_done"}, {30'd0, rd_valid, rd_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'd0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'd0);
        step();
        step();
        chk("reset_outs", 32'(outs()), 32'd0);
        reset = 1'b0;

        // full load, row-1 read, overflow, bad row, row-2 read with ignored rd_start
        for (int i = 0; i < 9; i++) begin
            add(1, 16'h0011 + 16'(i), 0, 0, 0, 0, 0, 16'h0, 9'(i + 1), i == 8, i == 8, 0);
        end
        add(0, 0,        0, 1, 1, 0, 0, 16'h0000, 9, 1, 0, 0);
        add(0, 0,        0, 0, 0, 1, 0, 16'h0014, 9, 1, 0, 0);
        add(0, 0,        0, 0, 0, 1, 0, 16'h0015, 9, 1, 0, 0);
        add(0, 0,        0, 0, 0, 1, 1, 16'h0016, 9, 1, 0, 0);
        add(0, 0,        0, 0, 0, 0, 0, 16'h0000, 9, 1, 1, 0);
        add(1, 16'hBEEF, 0, 0, 0, 0, 0, 16'h0000, 9, 1, 1, 1);
        add(0, 0,        0, 1, 3, 0, 0, 16'h0000, 9, 1, 1, 1);
        add(0, 0,        0, 0, 0, 0, 0, 16'h0000, 9, 1, 1, 1);
        add(0, 0,        0, 1, 2, 0, 0, 16'h0000, 9, 1, 0, 1);
        add(0, 0,        0, 0, 0, 1, 0, 16'h0017, 9, 1, 0, 1);
        add(0, 0,        0, 1, 0, 1, 0, 16'h0018, 9, 1, 0, 1);
        add(0, 0,        0, 0, 0, 1, 1, 16'h0019, 9, 1, 0, 1);
        add(0, 0,        0, 0, 0, 0, 0, 16'h0000, 9, 1, 1, 1);

        foreach (vq[i]) begin
            drive(vq[i].le, vq[i].d, vq[i].clr, vq[i].st, vq[i].row);
            step();
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vq[i].ev, vq[i].el, vq[i].ed, vq[i].ec, vq[i].eld, vq[i].erdy, vq[i].eovf}));
        end

        // clear on the first rd_valid cycle cuts the stream and empties the spad
        drive(1'b0, 16'h0, 1'b0, 1'b1, 4'd1);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'd0);
        step();
        chk("clr_first_valid", {15'd0, rd_valid, rd_data}, {15'd0, 1'b1, 16'h0014});
        drive(1'b1, 16'hDEAD, 1'b1, 1'b1, 4'd0);
        step();
        chk("clr_outs", 32'(outs()), 32'd0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'd0);
        step();
        chk("clr_stays_empty", 32'(outs()), 32'd0);
        load_words(9, 16'h0021);
        chk("clr_reload", {21'd0, wght_count, wght_loaded, rd_ready}, {21'd0, 9'd9, 1'b1, 1'b1});
        read_row("clr_row0", 4'd0, 16'h0021, 16'h0022, 16'h0023);

        // reset mid-load aborts; a fresh load then completes normally
        load_words(4, 16'h0031);
        reset = 1'b1;
        drive(1'b1, 16'h0035, 1'b0, 1'b0, 4'd0);
        step();
        chk("rst_midload_outs", 32'(outs()), 32'd0);
        reset = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'd0);
        step();
        chk("rst_idle_outs", 32'(outs()), 32'd0);
        load_words(9, 16'h0041);
        chk("rst_reload", {20'd0, wght_count, wght_loaded, rd_ready, load_overflow},
            {20'd0, 9'd9, 1'b1, 1'b1, 1'b0});
        read_row("rst_row2", 4'd2, 16'h0047, 16'h0048, 16'h0049);

        // short burst of 8 words terminated by load_en_spad low
        do_reset();
        load_words(8, 16'h0011);
        chk("short_in_load", {21'd0, wght_count, wght_loaded, rd_ready}, {21'd0, 9'd8, 1'b0, 1'b0});
        step();
        chk("short_ready", {21'd0, wght_count, wght_loaded, rd_ready}, {21'd0, 9'd8, 1'b1, 1'b1});
        read_row("short_row0", 4'd0, 16'h0011, 16'h0012, 16'h0013);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
